cache_set: RTL and testbench
============================

// Module: cache_set
// PURPOSE
//  One set of an i7-style set-associative cache (64-byte lines, 24-bit tags), write-through, allocate on any miss.
//  Performs one read, write or no-op per clock; line fills come from the next level on membanks.
//  Instantiated once per set index by the cache array; index decoding lives outside this block.
// PARAMETERS
//  WAYS       8    number of ways (power of two, 2..16)
//  TAG_W      24   tag width in bits
//  LINE_BYTES 64   line size in bytes (offset width = log2 = 6)
// PORTS
//  clk           in   1    rising-edge clock
//  rst_n         in   1    asynchronous active-low reset
//  enable        in   1    1 = accept op this cycle; 0 = idle, all state frozen
//  membanks      in   512  fill line from next level, byte 0 = bits[7:0]; valid in any miss cycle
//  write_en      in   3    op: 0 = read, 1 = write, 2 = no-op, others = no-op
//  block_offset  in   6    byte offset in line
//  write_data    in   64   store data, low bytes used per data_size
//  data_size     in   2    0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b
//  tag           in   24   tag of requested address
//  num_ops       in   32   debug op counter, ignored by logic
//  out_data      out  128  read data, zero-extended
//  miss_w        out  1    registered: last write missed
//  miss_r        out  1    registered: last read missed
//  data_ready    out  1    registered: out_data holds result of last read
// BEHAVIOUR
//  - Reset: all valid bits 0, LRU ages = way index, out_data = 0, miss_w = miss_r = data_ready = 0.
//  - Ops sampled on posedge with enable = 1; results registered, visible one cycle later (latency 1).
//  - Alignment: effective offset = block_offset with low data_size bits cleared; accesses never cross a line.
//  - Hit: exactly one valid way with matching tag (duplicates never created).
//  - Read hit: out_data <= zero-extended (1 << data_size) bytes at offset; data_ready <= 1, miss_r <= 0.
//  - Read miss: victim line <= membanks, tag set, valid set; out_data taken from membanks in the same edge;
//    data_ready <= 1, miss_r <= 1.
//  - Write hit: merge the sized bytes of write_data into the line; miss_w <= 0.
//  - Write miss: victim <= membanks with write bytes merged (write wins), tag and valid set; miss_w <= 1.
//  - Every write clears data_ready; out_data holds its value.
//  - No-op or enable = 0: no state change; out_data, data_ready, miss flags hold.
//  - Victim choice: lowest-index invalid way; if all ways valid, the way with the max LRU age.
//  - LRU: true LRU, per-way age log2(WAYS) bits. On access to way w, ages below age[w] increment and age[w] <= 0.
//    Ages stay a permutation of 0..WAYS-1.
//  - No dirty bits and no eviction output: write-through, the next level already holds the data.
//  - Reset asserted mid-op: op dropped, all state returns to reset values immediately.
// CONFIGURATION
//  CACHE_SET_STATS_EN defined:
//    - adds outputs hit_count[31:0] and miss_count[31:0].
//    - Each is a wrapping counter, reset to 0, incremented once per enabled read/write hit or miss.
//  CACHE_SET_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  cache_pkg: TAG_W, LINE_BYTES, OFFSET_W, op codes (OP_READ = 0, OP_WRITE = 1, OP_NOP = 2), size enum, line typedef.
//  Sub-module set_lru:
//    - age array, victim select, touch update.
//    - Inputs: clk, rst_n, touch, touch_way, valid vector. Output: victim_way.
//  Data/tag/valid arrays and byte merge stay in cache_set.
// TESTING
//  1. Reset, write tag 15, offset 0, size 3, data 8; then read tag 15, size 3 -> miss_w = 1 on the write; read gives
//     miss_r = 0, data_ready = 1, out_data = 8.
//  2. Write tag 16, offset 0, size 0, data 3; write tag 25, size 0, data 8; read tag 16 size 0 -> out_data = 3, hit.
//  3. Read tag 19 with membanks byte0 = 0x5A -> miss_r = 1, out_data = 0x5A; re-read tag 19 -> miss_r = 0.
//  4. Fill 8 tags, touch tag 1 again, access new tag 9 -> the LRU line (tag 2) is evicted; read tag 1 -> hit.
//  5. Write size 1, offset 3, data 0xBEEF -> bytes 2..3 written; read size 1, offset 2 -> 0xBEEF.
//  6. enable = 0 or write_en = 2 for 3 cycles -> outputs unchanged; assert rst_n low -> all outputs 0,
//     prior tags miss.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and types for one cache set.
// Op codes, access sizes and the default line type.
package cache_pkg;

  localparam int TAG_W      = 24;
  localparam int LINE_BYTES = 64;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_NOP   = 3'd2;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2,
    SZ_64 = 2'd3
  } size_e;

  typedef logic [LINE_BYTES*8-1:0] line_t;

endpackage

// File: rtl/cache_set_lru.sv
// True-LRU age tracking and victim selection for one set.
// Ages remain a permutation of 0..WAYS-1.
module set_lru #(
  parameter int WAYS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    touch,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic [WAYS-1:0]         valid,
  output logic [$clog2(WAYS)-1:0] victim_way
);

  localparam int AW = $clog2(WAYS);

  logic [AW-1:0] age [WAYS];
  logic          found;

  // Victim: lowest invalid way, else the oldest way
  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !valid[i]) begin
        victim_way = AW'(i);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age[i] == '1) victim_way = AW'(i);
      end
    end
  end

  // Touched way becomes youngest; younger ways age by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WAYS; i++) age[i] <= AW'(i);
    end else if (touch) begin
      for (int i = 0; i < WAYS; i++) begin
        if (AW'(i) == touch_way)
          age[i] <= '0;
        else if (age[i] < age[touch_way])
          age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_set.sv
// One write-through, allocate-on-miss set-associative cache set.
// Optional CACHE_SET_STATS_EN adds hit_count / miss_count outputs.
module cache_set #(
  parameter int WAYS       = 8,
  parameter int TAG_W      = 24,
  parameter int LINE_BYTES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [LINE_BYTES*8-1:0]       membanks,
  input  logic [2:0]                    write_en,
  input  logic [$clog2(LINE_BYTES)-1:0] block_offset,
  input  logic [63:0]                   write_data,
  input  logic [1:0]                    data_size,
  input  logic [TAG_W-1:0]              tag,
  input  logic [31:0]                   num_ops,
  output logic [127:0]                  out_data,
  output logic                          miss_w,
  output logic                          miss_r,
  output logic                          data_ready
`ifdef CACHE_SET_STATS_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
`endif
);

  import cache_pkg::*;

  localparam int AW    = $clog2(WAYS);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int LW    = LINE_BYTES * 8;

  logic [LW-1:0]    data_q [WAYS];
  logic [TAG_W-1:0] tag_q  [WAYS];
  logic [WAYS-1:0]  valid_q;

  logic             op_rd;
  logic             op_wr;
  logic             hit;
  logic             line_we;
  logic [AW-1:0]    hit_way;
  logic [AW-1:0]    victim_way;
  logic [AW-1:0]    way;
  logic [OFF_W-1:0] eff_off;
  logic [3:0]       nbytes;
  logic [63:0]      size_mask;
  logic [63:0]      rd_data;
  logic [LW-1:0]    base_line;
  logic [LW-1:0]    merged;
  logic [LW-1:0]    line_wdata;
  logic [2:0]       k;
  size_e            size;
  logic             unused_ok;

  assign unused_ok = ^num_ops;
  assign size      = size_e'(data_size);

  // Op decode; anything other than read/write is a no-op
  always_comb begin
    op_rd = 1'b0;
    op_wr = 1'b0;
    if (enable) begin
      unique case (1'b1)
        (write_en == OP_READ):  op_rd = 1'b1;
        (write_en == OP_WRITE): op_wr = 1'b1;
        default: ;
      endcase
    end
  end

  // Access width and data mask from the size code
  always_comb begin
    unique case (size)
      SZ_8:  begin nbytes = 4'd1; size_mask = 64'hFF;        end
      SZ_16: begin nbytes = 4'd2; size_mask = 64'hFFFF;      end
      SZ_32: begin nbytes = 4'd4; size_mask = 64'hFFFF_FFFF; end
      SZ_64: begin nbytes = 4'd8; size_mask = '1;            end
    endcase
  end

  assign eff_off = block_offset & ~OFF_W'(nbytes - 4'd1);

  // Tag match across valid ways
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && tag_q[i] == tag) begin
        hit     = 1'b1;
        hit_way = AW'(i);
      end
    end
  end

  assign way       = hit ? hit_way : victim_way;
  assign base_line = hit ? data_q[hit_way] : membanks;
  assign rd_data   = 64'(base_line >> {eff_off, 3'b000}) & size_mask;

  // Store bytes overlay the hit line or the incoming fill
  always_comb begin
    merged = base_line;
    k      = '0;
    for (int j = 0; j < LINE_BYTES; j++) begin
      if (j >= int'(eff_off) && j < int'(eff_off) + int'(nbytes)) begin
        k = 3'(j - int'(eff_off));
        merged[j*8 +: 8] = write_data[{k, 3'b000} +: 8];
      end
    end
  end

  assign line_we    = (op_rd && !hit) || op_wr;
  assign line_wdata = op_wr ? merged : membanks;

  set_lru #(.WAYS(WAYS)) u_lru (
    .clk        (clk),
    .rst_n      (rst_n),
    .touch      (op_rd || op_wr),
    .touch_way  (way),
    .valid      (valid_q),
    .victim_way (victim_way)
  );

  // Line storage; contents only meaningful while valid_q is set
  always_ff @(posedge clk) begin
    if (rst_n && line_we) data_q[way] <= line_wdata;
  end

  // Tags, valid bits and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      out_data   <= '0;
      miss_r     <= 1'b0;
      miss_w     <= 1'b0;
      data_ready <= 1'b0;
      for (int i = 0; i < WAYS; i++) tag_q[i] <= '0;
    end else begin
      if (line_we) begin
        valid_q[way] <= 1'b1;
        tag_q[way]   <= tag;
      end
      if (op_rd) begin
        out_data   <= {64'd0, rd_data};
        data_ready <= 1'b1;
        miss_r     <= !hit;
      end
      if (op_wr) begin
        data_ready <= 1'b0;
        miss_w     <= !hit;
      end
    end
  end

`ifdef CACHE_SET_STATS_EN
  // Wrapping hit/miss counters over enabled reads and writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (op_rd || op_wr) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_set.sv
// Directed bench for cache_set.
// Each task drives one scenario and checks inline.
module tb_cache_set;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [511:0] membanks;
  logic [2:0]   write_en;
  logic [5:0]   block_offset;
  logic [63:0]  write_data;
  logic [1:0]   data_size;
  logic [23:0]  tag;
  logic [31:0]  num_ops;
  logic [127:0] out_data;
  logic         miss_w;
  logic         miss_r;
  logic         data_ready;
`ifdef CACHE_SET_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [2:0] RD  = 3'd0;
  localparam logic [2:0] WR  = 3'd1;
  localparam logic [2:0] NOP = 3'd2;

  cache_set dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .membanks     (membanks),
    .write_en     (write_en),
    .block_offset (block_offset),
    .write_data   (write_data),
    .data_size    (data_size),
    .tag          (tag),
    .num_ops      (num_ops),
    .out_data     (out_data),
    .miss_w       (miss_w),
    .miss_r       (miss_r),
    .data_ready   (data_ready)
`ifdef CACHE_SET_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_op(input logic [2:0] op, input logic [23:0] t,
                       input logic [5:0] off, input logic [1:0] sz,
                       input logic [63:0] wd, input logic [511:0] mb);
    @(negedge clk);
    enable       = 1'b1;
    write_en     = op;
    tag          = t;
    block_offset = off;
    data_size    = sz;
    write_data   = wd;
    membanks     = mb;
    num_ops      = num_ops + 1;
    @(posedge clk);
    #1;
    write_en = NOP;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b0;
    write_en = NOP;
    membanks = '0;
    block_offset = '0;
    write_data = '0;
    data_size = '0;
    tag = '0;
    num_ops = '0;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL rst_out got=%h exp=0", out_data); end
    n_run++; if (miss_w !== 1'b0) begin n_fail++; $display("FAIL rst_miss_w got=%b exp=0", miss_w); end
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL rst_miss_r got=%b exp=0", miss_r); end
    n_run++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dr got=%b exp=0", data_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    apply_reset();
    do_op(WR, 24'd15, 6'd0, 2'd3, 64'd8, {64{8'hAA}});
    n_run++; if (miss_w !== 1'b1) begin n_fail++; $display("FAIL t1_miss_w got=%b exp=1", miss_w); end
    n_run++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL t1_dr_wr got=%b exp=0", data_ready); end
    do_op(RD, 24'd15, 6'd0, 2'd3, 64'd0, '0);
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t1_miss_r got=%b exp=0", miss_r); end
    n_run++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL t1_dr got=%b exp=1", data_ready); end
    n_run++; if (out_data !== 128'd8) begin n_fail++; $display("FAIL t1_out got=%h exp=8", out_data); end
    do_op(RD, 24'd15, 6'd8, 2'd3, 64'd0, '0);
    n_run++; if (out_data !== 128'hAAAA_AAAA_AAAA_AAAA) begin n_fail++; $display("FAIL t1_fill got=%h exp=aaaaaaaaaaaaaaaa", out_data); end
  endtask

  task automatic test_byte_write;
    do_op(WR, 24'd16, 6'd0, 2'd0, 64'd3, '0);
    n_run++; if (miss_w !== 1'b1) begin n_fail++; $display("FAIL t2_miss_w got=%b exp=1", miss_w); end
    do_op(WR, 24'd25, 6'd0, 2'd0, 64'd8, '0);
    do_op(RD, 24'd16, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t2_miss_r got=%b exp=0", miss_r); end
    n_run++; if (out_data !== 128'd3) begin n_fail++; $display("FAIL t2_out16 got=%h exp=3", out_data); end
    do_op(RD, 24'd25, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (out_data !== 128'd8) begin n_fail++; $display("FAIL t2_out25 got=%h exp=8", out_data); end
  endtask

  task automatic test_read_miss;
    do_op(RD, 24'd19, 6'd0, 2'd0, 64'd0, 512'h5A);
    n_run++; if (miss_r !== 1'b1) begin n_fail++; $display("FAIL t3_miss got=%b exp=1", miss_r); end
    n_run++; if (out_data !== 128'h5A) begin n_fail++; $display("FAIL t3_out got=%h exp=5a", out_data); end
    do_op(RD, 24'd19, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t3_rehit got=%b exp=0", miss_r); end
    n_run++; if (out_data !== 128'h5A) begin n_fail++; $display("FAIL t3_reout got=%h exp=5a", out_data); end
    do_op(WR, 24'd19, 6'd1, 2'd0, 64'h77, '0);
    n_run++; if (miss_w !== 1'b0) begin n_fail++; $display("FAIL t3_wmiss got=%b exp=0", miss_w); end
    n_run++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL t3_wdr got=%b exp=0", data_ready); end
    n_run++; if (out_data !== 128'h5A) begin n_fail++; $display("FAIL t3_whold got=%h exp=5a", out_data); end
    do_op(RD, 24'd19, 6'd0, 2'd1, 64'd0, '0);
    n_run++; if (out_data !== 128'h775A) begin n_fail++; $display("FAIL t3_merge got=%h exp=775a", out_data); end
  endtask

  task automatic test_lru;
    logic [7:0] b;
    apply_reset();
    for (int t = 1; t <= 8; t++) begin
      b = 8'(t);
      do_op(RD, 24'(t), 6'd0, 2'd0, 64'd0, {64{b}});
      n_run++; if (miss_r !== 1'b1) begin n_fail++; $display("FAIL t4_fill%0d got=%b exp=1", t, miss_r); end
    end
    do_op(RD, 24'd1, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t4_touch1 got=%b exp=0", miss_r); end
    n_run++; if (out_data !== 128'd1) begin n_fail++; $display("FAIL t4_touch1d got=%h exp=1", out_data); end
    do_op(RD, 24'd9, 6'd0, 2'd0, 64'd0, {64{8'h09}});
    n_run++; if (miss_r !== 1'b1) begin n_fail++; $display("FAIL t4_new9 got=%b exp=1", miss_r); end
    n_run++; if (out_data !== 128'd9) begin n_fail++; $display("FAIL t4_new9d got=%h exp=9", out_data); end
    do_op(RD, 24'd1, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t4_hit1 got=%b exp=0", miss_r); end
    n_run++; if (out_data !== 128'd1) begin n_fail++; $display("FAIL t4_hit1d got=%h exp=1", out_data); end
    do_op(RD, 24'd3, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t4_hit3 got=%b exp=0", miss_r); end
    n_run++; if (out_data !== 128'd3) begin n_fail++; $display("FAIL t4_hit3d got=%h exp=3", out_data); end
    do_op(RD, 24'd2, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (miss_r !== 1'b1) begin n_fail++; $display("FAIL t4_evict2 got=%b exp=1", miss_r); end
  endtask

  task automatic test_halfword;
    do_op(WR, 24'd40, 6'd3, 2'd1, 64'hBEEF, '0);
    n_run++; if (miss_w !== 1'b1) begin n_fail++; $display("FAIL t5_miss_w got=%b exp=1", miss_w); end
    do_op(RD, 24'd40, 6'd2, 2'd1, 64'd0, '0);
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t5_miss_r got=%b exp=0", miss_r); end
    n_run++; if (out_data !== 128'hBEEF) begin n_fail++; $display("FAIL t5_hw got=%h exp=beef", out_data); end
    do_op(RD, 24'd40, 6'd3, 2'd0, 64'd0, '0);
    n_run++; if (out_data !== 128'hBE) begin n_fail++; $display("FAIL t5_b3 got=%h exp=be", out_data); end
    do_op(RD, 24'd40, 6'd0, 2'd2, 64'd0, '0);
    n_run++; if (out_data !== 128'hBEEF_0000) begin n_fail++; $display("FAIL t5_w0 got=%h exp=beef0000", out_data); end
    do_op(RD, 24'd40, 6'd4, 2'd0, 64'd0, '0);
    n_run++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL t5_b4 got=%h exp=0", out_data); end
  endtask

  task automatic test_hold;
    logic [2:0] ops [6];
    logic       ens [6];
    ops = '{RD, WR, RD, NOP, 3'd5, 3'd7};
    ens = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_op(RD, 24'd40, 6'd2, 2'd1, 64'd0, '0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      enable     = ens[c];
      write_en   = ops[c];
      tag        = 24'd99;
      write_data = 64'h1234;
      membanks   = {16{32'hDEAD_BEEF}};
      @(posedge clk);
      #1;
      n_run++; if (out_data !== 128'hBEEF) begin n_fail++; $display("FAIL t6_out%0d got=%h exp=beef", c, out_data); end
      n_run++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL t6_dr%0d got=%b exp=1", c, data_ready); end
      n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t6_mr%0d got=%b exp=0", c, miss_r); end
      n_run++; if (miss_w !== 1'b1) begin n_fail++; $display("FAIL t6_mw%0d got=%b exp=1", c, miss_w); end
    end
    do_op(RD, 24'd99, 6'd0, 2'd0, 64'd0, '0);
    n_run++; if (miss_r !== 1'b1) begin n_fail++; $display("FAIL t6_noalloc got=%b exp=1", miss_r); end
    @(negedge clk);
    enable     = 1'b1;
    write_en   = WR;
    tag        = 24'd40;
    write_data = 64'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    n_run++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL t6_rst_out got=%h exp=0", out_data); end
    n_run++; if (miss_r !== 1'b0) begin n_fail++; $display("FAIL t6_rst_mr got=%b exp=0", miss_r); end
    n_run++; if (miss_w !== 1'b0) begin n_fail++; $display("FAIL t6_rst_mw got=%b exp=0", miss_w); end
    @(posedge clk);
    #1;
    n_run++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL t6_rst_dr got=%b exp=0", data_ready); end
    @(negedge clk);
    write_en = NOP;
    rst_n    = 1'b1;
    do_op(RD, 24'd40, 6'd2, 2'd1, 64'd0, '0);
    n_run++; if (miss_r !== 1'b1) begin n_fail++; $display("FAIL t6_post_miss got=%b exp=1", miss_r); end
    n_run++; if (out_data !== 128'd0) begin n_fail++; $display("FAIL t6_post_out got=%h exp=0", out_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_read_miss();
    test_lru();
    test_halfword();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
